alu_md: RTL and testbench

Parametrised successor to the pipeline's combinational ALU. It keeps every existing single-cycle operation, generalised to `WIDTH` bits. It adds an iterative multiply/divide unit with architectural HI/LO registers and a start/busy handshake toward the EX-stage hazard logic. It sits in the EX stage, and its `stall` output feeds the pipeline stall network.

---
 rtl/alu_md.sv | 218 +++++++++++++++++++++
 tb/tb_alu_md.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// alu_md: EX-stage ALU with single-cycle ops plus an iterative multiply/divide
// unit that owns the architectural HI/LO registers.
// Optional feature macro: ALU_MD_DIV_EN. When defined, the restoring divider
// (ops 1100/1101) is built. When undefined, those ops are inert no-ops.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       aluop,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULT  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
`ifdef ALU_MD_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
`endif
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 res_neg_q;
  logic                 done_q;
`ifdef ALU_MD_DIV_EN
  logic                 is_div_q;
  logic                 rem_neg_q;
  logic                 div0_q;
`endif

  // Two's-complement sign correction, applied only when en is set.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  logic signed [WIDTH-1:0] in1_s, in2_s;
  logic                    signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]        a_mag, b_mag;
  logic                    is_mul_op, is_div_op, is_mf_op, issue;

  assign in1_s     = input1;
  assign in2_s     = input2;
  // MULT and DIV have aluop[0] clear; the unsigned variants have it set.
  assign signed_op = ~aluop[0];
  assign a_neg     = signed_op & in1_s[WIDTH-1];
  assign b_neg     = signed_op & in2_s[WIDTH-1];
  assign a_mag     = neg_w(input1, a_neg);
  assign b_mag     = neg_w(input2, b_neg);

  assign is_mul_op = (aluop == OP_MULT) || (aluop == OP_MULTU);
`ifdef ALU_MD_DIV_EN
  assign is_div_op = (aluop == OP_DIV) || (aluop == OP_DIVU);
`else
  assign is_div_op = 1'b0;
`endif
  assign is_mf_op  = (aluop == OP_MFHI) || (aluop == OP_MFLO);

  assign busy  = (state_q != S_IDLE);
  assign issue = in_valid & (is_mul_op | is_div_op) & (state_q == S_IDLE);
  assign stall = in_valid & busy & (is_mul_op | is_div_op | is_mf_op);
  assign done  = done_q;

  // Single-cycle result mux; MD ops and unused codes read as zero.
  always_comb begin
    out = '0;
    case (aluop)
      OP_ADD:  out = input1 + input2;
      OP_SUB:  out = input1 - input2;
      OP_SLL:  out = input2 << input1[SHW-1:0];
      OP_SRL:  out = input2 >> input1[SHW-1:0];
      OP_SRA:  out = in2_s >>> input1[SHW-1:0];
      OP_SLT:  out = {{(WIDTH-1){1'b0}}, (in1_s < in2_s)};
      OP_SLTU: out = {{(WIDTH-1){1'b0}}, (input1 < input2)};
      OP_AND:  out = input1 & input2;
      OP_OR:   out = input1 | input2;
      OP_XOR:  out = input1 ^ input2;
      OP_MFHI: out = hi_q;
      OP_MFLO: out = lo_q;
      default: out = '0;
    endcase
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (acc LSB) is set, then shift right one place.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef ALU_MD_DIV_EN
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  // Restoring step: upper half is the partial remainder, lower half the
  // dividend being shifted out while quotient bits shift in.
  always_comb begin
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, opnd_q}) : div_sh[WIDTH-1:0];
    div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end
`endif

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  // Final sign correction of the unsigned magnitude result before HI/LO write.
  always_comb begin
    prod_fix = neg_2w(acc_q, res_neg_q);
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
`ifdef ALU_MD_DIV_EN
    if (is_div_q) begin
      lo_fix = div0_q ? '1 : neg_w(acc_q[WIDTH-1:0], res_neg_q);
      hi_fix = neg_w(acc_q[2*WIDTH-1:WIDTH], rem_neg_q);
    end
`endif
  end

  // Next-state logic: WIDTH iteration cycles, then one fix-up cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = is_mul_op ? S_MUL : S_DIV;
          cnt_d   = '0;
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, done pulse and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == S_FIX);
      if (state_q == S_FIX) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
    end
  end

  // Operand capture at issue and per-cycle iteration of the accumulator.
  always_ff @(posedge clk) begin
    if (issue) begin
      opnd_q    <= is_mul_op ? a_mag : b_mag;
      acc_q     <= {{WIDTH{1'b0}}, (is_mul_op ? b_mag : a_mag)};
      res_neg_q <= a_neg ^ b_neg;
`ifdef ALU_MD_DIV_EN
      is_div_q  <= is_div_op;
      rem_neg_q <= a_neg;
      div0_q    <= (input2 == '0);
`endif
    end else if (state_q == S_MUL) begin
      acc_q <= mul_next;
    end
`ifdef ALU_MD_DIV_EN
    else if (state_q == S_DIV) begin
      acc_q <= div_next;
    end
`endif
  end

endmodule

// File: tb/tb_alu_md.sv
// Testbench for alu_md: behavioural HI/LO/timing model with a per-cycle
// compare process, plus directed vectors with literal expectations.
module tb_alu_md;

  localparam int W = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid;
  logic [31:0] input1, input2, out;
  logic [3:0]  aluop;
  logic        busy, stall, done;

  logic        v16, busy16, stall16, done16;
  logic [15:0] a16, b16, o16;
  logic [3:0]  op16;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .input1(input1), .input2(input2),
    .aluop(aluop), .out(out), .busy(busy), .stall(stall), .done(done)
  );

  alu_md #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .input1(a16), .input2(b16),
    .aluop(op16), .out(o16), .busy(busy16), .stall(stall16), .done(done16)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [3:0] op);
    bit r;
    r = (op == 4'd10) || (op == 4'd11);
`ifdef ALU_MD_DIV_EN
    r = r || (op == 4'd12) || (op == 4'd13);
`endif
    return r;
  endfunction

  function automatic logic [31:0] exp_out(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
    int sa, sb, sh;
    sa = a;
    sb = b;
    sh = {27'd0, a[4:0]};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return b << sh;
      4'd3:  return b >> sh;
      4'd9:  return sb >>> sh;
      4'd4:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a & b;
      4'd6:  return a | b;
      4'd7:  return a ^ b;
      4'd14: return hi;
      4'd15: return lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic compute_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
    longint          p;
    longint unsigned pu;
    int              q, r;
    hi = '0;
    lo = '0;
    case (op)
      4'd10: begin
        p  = longint'(int'(a)) * longint'(int'(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      4'd11: begin
        pu = {32'd0, a} * {32'd0, b};
        hi = pu[63:32];
        lo = pu[31:0];
      end
      4'd12: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 32'd0; end
        else begin q = int'(a) / int'(b); r = int'(a) % int'(b); lo = q; hi = r; end
      end
      4'd13: begin
        if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endtask

  // Model: busy lasts W+1 cycles after issue; HI/LO and done follow.
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
      end else if (in_valid && is_md(aluop)) begin
        compute_md(aluop, input1, input2, p_hi, p_lo);
        m_rem = W + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit mb;
    if (chk_en) begin
      mb = (m_rem > 0);
      chk("busy", busy, mb);
      chk("done", done, m_done);
      chk("stall", stall, in_valid && mb && (is_md(aluop) || aluop >= 4'd14));
      chk("out", out, exp_out(aluop, input1, input2, m_hi, m_lo));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called in cycle E0+1; returns in the done cycle (or at the budget).
  task automatic wait_done(output int cycles, output int bcyc);
    cycles = 1;
    bcyc   = 0;
    while (!done && cycles < 60) begin
      if (busy) bcyc++;
      tick(1);
      cycles++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
    in_valid = 1'b1;
    aluop = 4'd14; #1 hi = out;
    aluop = 4'd15; #1 lo = out;
    in_valid = 1'b0;
    aluop = 4'd0;
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    int c, bc;
    in_valid = 1'b1; aluop = op; input1 = a; input2 = b;
    tick(1);
    in_valid = 1'b0; aluop = 4'd0;
    wait_done(c, bc);
    chk("md_latency", c, W + 2);
    read_hl(hi, lo);
  endtask

  logic [3:0]  t_op [8] = '{4'd0, 4'd2, 4'd3, 4'd9, 4'd5, 4'd6, 4'd7, 4'd4};
  logic [31:0] t_a  [8] = '{32'h7FFF_FFFF, 32'd31, 32'd8, 32'd31, 32'hF0F0_F0F0,
                            32'hF0F0_F0F0, 32'hFFFF_0000, 32'h8000_0000};
  logic [31:0] t_b  [8] = '{32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'h0FF0_0FF0,
                            32'h0FF0_0FF0, 32'h0F0F_0F0F, 32'h7FFF_FFFF};

  initial begin
    logic [31:0] hi, lo;
    int c, bc, sc, dc;

    rst = 1'b1; in_valid = 1'b0; aluop = 4'd0; input1 = '0; input2 = '0;
    v16 = 1'b0; op16 = 4'd0; a16 = '0; b16 = '0;
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    in_valid = 1'b1; aluop = 4'd14; #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_mfhi", out, 32'd0);
    aluop = 4'd15; #1 chk("rst_mflo", out, 32'd0);
    in_valid = 1'b0;
    tick(1);

    // Combinational vectors with literal results.
    aluop = 4'd1; input1 = 32'd5; input2 = 32'd7; #1 chk("sub", out, 32'hFFFF_FFFE);
    aluop = 4'd9; input1 = 32'd4; input2 = 32'h8000_0000; #1 chk("sra", out, 32'hF800_0000);
    aluop = 4'd4; input1 = 32'hFFFF_FFFF; input2 = 32'd1; #1 chk("slt", out, 32'd1);
    aluop = 4'd8; #1 chk("sltu", out, 32'd0);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      aluop = t_op[i]; input1 = t_a[i]; input2 = t_b[i];
      tick(1);
    end

    // MULT -3 x 7: latency, busy length, MFLO in the done cycle.
    in_valid = 1'b1; aluop = 4'd10; input1 = 32'hFFFF_FFFD; input2 = 32'd7;
    tick(1);
    in_valid = 1'b0; aluop = 4'd0; input1 = 32'd1; input2 = 32'd2;
    wait_done(c, bc);
    chk("mult_latency", c, 34);
    chk("mult_busy_cycles", bc, 33);
    in_valid = 1'b1; aluop = 4'd15; #1 chk("mult_mflo_done", out, 32'hFFFF_FFEB);
    aluop = 4'd14; #1 chk("mult_mfhi", out, 32'hFFFF_FFFF);
    chk("mult_done_still", done, 1'b1);
    in_valid = 1'b0;
    tick(1);

    // MULTU with ADD then MFHI waiting behind it; back-to-back MULT in done cycle.
    in_valid = 1'b1; aluop = 4'd11; input1 = 32'h1234_5678; input2 = 32'h10;
    tick(1);
    aluop = 4'd0; #1 chk("add_nostall", stall, 1'b0);
    tick(1);
    aluop = 4'd14; #1;
    c = 2; sc = 0;
    while (!done && c < 60) begin
      if (stall) sc++;
      tick(1);
      c++;
    end
    chk("mfhi_stall_cycles", sc, 32);
    chk("mfhi_done_nostall", stall, 1'b0);
    chk("mfhi_new_hi", out, 32'h1);
    aluop = 4'd10; input1 = 32'h7FFF_FFFF; input2 = 32'hFFFF_FFFF;
    tick(1);
    chk("b2b_busy", busy, 1'b1);
    in_valid = 1'b0; aluop = 4'd0;
    wait_done(c, bc);
    read_hl(hi, lo);
    chk("b2b_hi", hi, 32'hFFFF_FFFF);
    chk("b2b_lo", lo, 32'h8000_0001);
    tick(1);

    // Reset in cycle E0+10 of a MULTU.
    in_valid = 1'b1; aluop = 4'd11; input1 = 32'hFFFF_FFFF; input2 = 32'd2;
    tick(1);
    in_valid = 1'b0; aluop = 4'd0;
    tick(9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    read_hl(hi, lo);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    dc = 0;
    repeat (40) begin if (done) dc++; tick(1); end
    chk("abort_no_done", dc, 0);
    run_md(4'd11, 32'hFFFF_FFFF, 32'd2, hi, lo);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    tick(1);

`ifdef ALU_MD_DIV_EN
    run_md(4'd12, 32'hFFFF_FFF9, 32'd2, hi, lo);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_md(4'd13, 32'd7, 32'd0, hi, lo);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd7);
    run_md(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);
    run_md(4'd12, 32'hFFFF_FFF9, 32'd0, hi, lo);
    chk("div0s_hi", hi, 32'hFFFF_FFF9);
    run_md(4'd13, 32'd100, 32'd7, hi, lo);
`else
    in_valid = 1'b1; aluop = 4'd12; input1 = 32'd8; input2 = 32'd2;
    tick(1);
    chk("nodiv_busy0", busy, 1'b0);
    tick(3);
    chk("nodiv_busy1", busy, 1'b0);
    in_valid = 1'b0;
    read_hl(hi, lo);
    chk("nodiv_hi", hi, 32'h1);
    chk("nodiv_lo", lo, 32'hFFFF_FFFE);
    in_valid = 1'b1; aluop = 4'd11; input1 = 32'd3; input2 = 32'd5;
    tick(1);
    aluop = 4'd13; #1 chk("nodiv_nostall", stall, 1'b0);
    in_valid = 1'b0; aluop = 4'd0;
    wait_done(c, bc);
    tick(1);
`endif

    // More products for the model only.
    run_md(4'd10, 32'h8000_0000, 32'h8000_0000, hi, lo);
    run_md(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    run_md(4'd10, 32'd0, 32'hDEAD_BEEF, hi, lo);
    tick(1);

    // WIDTH=16 instance: MULTU 0xFFFF x 0xFFFF in 18 cycles.
    v16 = 1'b1; op16 = 4'd11; a16 = 16'hFFFF; b16 = 16'hFFFF;
    tick(1);
    v16 = 1'b0; op16 = 4'd0;
    c = 1;
    while (!done16 && c < 40) begin tick(1); c++; end
    chk("w16_done_seen", done16, 1'b1);
    chk("w16_latency", c, 18);
    v16 = 1'b1; op16 = 4'd14; #1 chk("w16_hi", {16'd0, o16}, 32'h0000_FFFE);
    op16 = 4'd15; #1 chk("w16_lo", {16'd0, o16}, 32'h0000_0001);
    v16 = 1'b0;

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
